// File: rtl/soc_line_pkg.sv
// Shared definitions for the AHB line-coordinate controller: register offsets,
// CTRL bit positions, default coordinate limits and the commit FSM state type.
package soc_line_pkg;

    // Word offsets, as seen on HADDR[4:2]
    localparam logic [2:0] ADDR_X1     = 3'd0;
    localparam logic [2:0] ADDR_Y1     = 3'd1;
    localparam logic [2:0] ADDR_X2     = 3'd2;
    localparam logic [2:0] ADDR_Y2     = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // CTRL register bit positions
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_ABORT_BIT  = 1;

    // Default coordinate limits for a 320x240 display
    localparam int X_MAX_DEFAULT = 319;
    localparam int Y_MAX_DEFAULT = 239;

    // Commit FSM: a committed line waits in PENDING for the next frame boundary
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } line_state_e;

    // Saturate a 9-bit coordinate to its legal maximum
    function automatic logic [8:0] clamp9(input logic [8:0] value, input logic [8:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// Brings the asynchronous active-low vertical sync into the CLOCK_50 domain and
// produces a single-cycle pulse on each synchronised 1->0 transition.
module sync_fall_detect (
    input  logic CLOCK_50,
    input  logic HRESETn,
    input  logic async_in,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    // Two-flop synchroniser followed by one delay flop for edge detection
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a true shift chain; blocking ones would collapse the flops into one.
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    // Falling edge of the synchronised signal
    assign fall = sync_d & ~sync;

endmodule

// File: rtl/ahb_line_ctrl.sv
// AHB-Lite slave holding a line's end-point coordinates. Software writes shadow
// registers and commits; the active coordinates update at the next frame start
// (vertical sync falling edge), so the display never sees a half-updated line.
module ahb_line_ctrl
    import soc_line_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEFAULT,
    parameter int Y_MAX = Y_MAX_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        VGA_VS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [8:0]  x1,
    output logic [8:0]  y1,
    output logic [8:0]  x2,
    output logic [8:0]  y2
);

    localparam logic [8:0] X_LIM = X_MAX[8:0];
    localparam logic [8:0] Y_LIM = Y_MAX[8:0];

    // Address-phase information carried into the data phase
    logic       ap_valid;
    logic       ap_write;
    logic [2:0] ap_addr;

    logic [8:0] sh_x1, sh_y1, sh_x2, sh_y2;
    logic [7:0] frame_cnt;
    logic       vs_fall;

    line_state_e state, state_next;
    logic        load_active;

    logic wr_data;
    logic ctrl_wr;
    logic commit_req;
    logic abort_req;

    // Bits of the bus that this slave deliberately does not decode
    logic unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:9], HTRANS[0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    sync_fall_detect u_vs_sync (
        .CLOCK_50 (CLOCK_50),
        .HRESETn  (HRESETn),
        .async_in (VGA_VS),
        .fall     (vs_fall)
    );

    // Capture the address phase; HREADY low means the bus is stalled, so hold
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_addr  <= 3'd0;
        end else if (HREADY) begin
            ap_valid <= HSEL & HTRANS[1];
            ap_write <= HWRITE;
            ap_addr  <= HADDR[4:2];
        end
    end

    assign wr_data    = ap_valid & ap_write;
    assign ctrl_wr    = wr_data && (ap_addr == ADDR_CTRL);
    assign abort_req  = ctrl_wr & HWDATA[CTRL_ABORT_BIT];
    assign commit_req = ctrl_wr & HWDATA[CTRL_COMMIT_BIT] & ~HWDATA[CTRL_ABORT_BIT];

    // Shadow registers, written at the end of the data phase with saturation
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            sh_x1 <= 9'd0;
            sh_y1 <= 9'd0;
            sh_x2 <= 9'd0;
            sh_y2 <= 9'd0;
        end else if (wr_data) begin
            case (ap_addr)
                ADDR_X1: sh_x1 <= clamp9(HWDATA[8:0], X_LIM);
                ADDR_Y1: sh_y1 <= clamp9(HWDATA[8:0], Y_LIM);
                ADDR_X2: sh_x2 <= clamp9(HWDATA[8:0], X_LIM);
                ADDR_Y2: sh_y2 <= clamp9(HWDATA[8:0], Y_LIM);
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and active-register load; ABORT outranks a same-cycle frame start
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_next  = state;
        load_active = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_req) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (abort_req) begin
                    state_next = ST_IDLE;
                end else if (vs_fall) begin
                    state_next  = ST_IDLE;
                    load_active = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Active coordinates: copy the shadow set at the frame boundary
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            x1 <= 9'd0;
            y1 <= 9'd0;
            x2 <= 9'd0;
            y2 <= 9'd0;
        end else if (load_active) begin
            x1 <= sh_x1;
            y1 <= sh_y1;
            x2 <= sh_x2;
            y2 <= sh_y2;
        end
    end

    // Frame counter, wraps naturally at 8 bits
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            frame_cnt <= 8'd0;
        end else if (vs_fall) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Read mux driven from the registered address phase
    always_comb begin
        HRDATA = 32'd0;
        if (ap_valid && !ap_write) begin
            case (ap_addr)
                ADDR_X1:     HRDATA = {23'd0, sh_x1};
                ADDR_Y1:     HRDATA = {23'd0, sh_y1};
                ADDR_X2:     HRDATA = {23'd0, sh_x2};
                ADDR_Y2:     HRDATA = {23'd0, sh_y2};
                ADDR_STATUS: HRDATA = {16'd0, frame_cnt, 7'd0, (state == ST_PENDING)};
                default:     HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_line_ctrl.sv
// Directed bench for ahb_line_ctrl: shadow writes, clamping, commit/abort,
// frame-boundary coincidences, frame counter wrap and reset while pending.
module tb_ahb_line_ctrl;

    logic        CLOCK_50;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        VGA_VS;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [8:0]  x1, y1, x2, y2;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd;

    localparam logic [31:0] A_X1     = 32'h00;
    localparam logic [31:0] A_Y1     = 32'h04;
    localparam logic [31:0] A_X2     = 32'h08;
    localparam logic [31:0] A_Y2     = 32'h0C;
    localparam logic [31:0] A_CTRL   = 32'h10;
    localparam logic [31:0] A_STATUS = 32'h14;

    ahb_line_ctrl dut (
        .CLOCK_50  (CLOCK_50),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .VGA_VS    (VGA_VS),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_xy(input string tag, input int ex1, input int ey1, input int ex2, input int ey2);
        check({tag, " x1"}, {23'd0, x1}, ex1);
        check({tag, " y1"}, {23'd0, y1}, ey1);
        check({tag, " x2"}, {23'd0, x2}, ex2);
        check({tag, " y2"}, {23'd0, y2}, ey2);
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLOCK_50);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(negedge CLOCK_50);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        @(negedge CLOCK_50);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge CLOCK_50);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(negedge CLOCK_50);
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic vs_pulse();
        @(negedge CLOCK_50);
        VGA_VS = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        VGA_VS = 1'b1;
        repeat (3) @(negedge CLOCK_50);
    endtask

    // Start a VS falling edge and place a write's data phase on the vs_fall cycle
    task automatic write_on_vs_fall(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLOCK_50);
        VGA_VS = 1'b0;
        @(negedge CLOCK_50);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(negedge CLOCK_50);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        @(negedge CLOCK_50);
    endtask

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = 32'd0; HREADY = 1'b1; VGA_VS = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("reset hrdata", HRDATA, 32'd0);
        check("reset hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("reset hresp", {31'd0, HRESP}, 32'd0);
        HRESETn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check_xy("reset", 0, 0, 0, 0);
        ahb_read(A_STATUS, rd);
        check("reset status", rd, 32'h000);

        // Basic commit
        ahb_write(A_X1, 32'd10);
        ahb_write(A_Y1, 32'd20);
        ahb_write(A_X2, 32'd300);
        ahb_write(A_Y2, 32'd200);
        ahb_write(A_CTRL, 32'd1);
        ahb_read(A_STATUS, rd);
        check("pending status", rd, 32'h001);
        check_xy("before vs", 0, 0, 0, 0);
        vs_pulse();
        check_xy("commit", 10, 20, 300, 200);
        ahb_read(A_STATUS, rd);
        check("after commit status", rd, 32'h100);

        // Clamping and ignored upper data bits
        ahb_write(A_X2, 32'h1FF);
        ahb_write(A_Y2, 32'd400);
        ahb_write(A_X1, 32'hFFFF_FE05);
        ahb_read(A_X2, rd);
        check("x2 clamp read", rd, 32'd319);
        ahb_read(A_Y2, rd);
        check("y2 clamp read", rd, 32'd239);
        ahb_read(A_X1, rd);
        check("x1 upper bits", rd, 32'd5);
        ahb_read(A_CTRL, rd);
        check("ctrl read", rd, 32'd0);
        ahb_read(32'h18, rd);
        check("unmapped read", rd, 32'd0);
        check_xy("shadow only", 10, 20, 300, 200);
        ahb_write(A_CTRL, 32'd1);
        vs_pulse();
        check_xy("clamp commit", 5, 20, 319, 239);

        // Abort before the frame boundary
        ahb_write(A_X1, 32'd100);
        ahb_write(A_CTRL, 32'd1);
        ahb_write(A_CTRL, 32'd2);
        ahb_read(A_STATUS, rd);
        check("abort status", rd, 32'h200);
        for (int f = 0; f < 3; f++) begin
            vs_pulse();
            check_xy("abort frame", 5, 20, 319, 239);
        end
        ahb_write(A_CTRL, 32'd3);
        ahb_write(A_STATUS, 32'hFFFF_FFFF);
        ahb_read(A_STATUS, rd);
        check("both bits idle", rd, 32'h500);

        // COMMIT data phase coincident with vs_fall
        write_on_vs_fall(A_CTRL, 32'd1);
        check_xy("coincident commit edge", 5, 20, 319, 239);
        VGA_VS = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        ahb_read(A_STATUS, rd);
        check("coincident pending", rd, 32'h601);
        vs_pulse();
        check_xy("coincident next vs", 100, 20, 319, 239);
        ahb_read(A_STATUS, rd);
        check("coincident done", rd, 32'h700);

        // Shadow write coincident with the transfer vs_fall
        ahb_write(A_CTRL, 32'd1);
        write_on_vs_fall(A_Y1, 32'd77);
        check_xy("old shadow latched", 100, 20, 319, 239);
        VGA_VS = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        ahb_read(A_Y1, rd);
        check("new shadow y1", rd, 32'd77);
        ahb_read(A_STATUS, rd);
        check("transfer idle", rd, 32'h800);

        // Reset while pending
        ahb_write(A_X1, 32'd50);
        ahb_write(A_Y1, 32'd50);
        ahb_write(A_X2, 32'd50);
        ahb_write(A_Y2, 32'd50);
        ahb_write(A_CTRL, 32'd1);
        ahb_read(A_STATUS, rd);
        check("pre-reset status", rd, 32'h801);
        @(negedge CLOCK_50);
        #3 HRESETn = 1'b0;
        #1 check_xy("async reset", 0, 0, 0, 0);
        repeat (2) @(negedge CLOCK_50);
        HRESETn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        ahb_read(A_STATUS, rd);
        check("post-reset status", rd, 32'h000);
        ahb_read(A_X1, rd);
        check("post-reset shadow", rd, 32'd0);
        vs_pulse();
        vs_pulse();
        check_xy("no update after reset", 0, 0, 0, 0);
        ahb_read(A_STATUS, rd);
        check("post-reset frames", rd, 32'h200);

        // Frame counter wrap: 256 pulses since reset, then one more
        for (int p = 0; p < 254; p++) vs_pulse();
        ahb_read(A_STATUS, rd);
        check("frame wrap", rd, 32'h000);
        vs_pulse();
        ahb_read(A_STATUS, rd);
        check("frame after wrap", rd, 32'h100);
        check_xy("final", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_line_ctrl.md
AHB_LINE_CTRL -- requirements
Module: ahb_line_ctrl

Interface
REQ-001 Parameters, one per line: X_MAX, default 319, largest legal x coordinate; Y_MAX, default 239, largest legal y coordinate.
REQ-002 CLOCK_50  in  1  system clock, also used as HCLK; all logic on its rising edge.
REQ-003 HRESETn  in  1  reset, asynchronous, active-low.
REQ-004 HSEL  in  1  slave select.
REQ-005 HADDR  in  32  address; only HADDR[4:2] decoded.
REQ-006 HTRANS  in  2  transfer type; NONSEQ or SEQ means active.
REQ-007 HWRITE  in  1  1 = write.
REQ-008 HSIZE  in  3  ignored; all accesses treated as 32-bit.
REQ-009 HWDATA  in  32  write data, valid in data phase.
REQ-010 HREADY  in  1  bus ready; qualifies the address phase.
REQ-011 VGA_VS  in  1  vertical sync from the display generator, active-low, asynchronous to CLOCK_50.
REQ-012 HRDATA  out  32  read data.
REQ-013 HREADYOUT  out  1  constant 1, no wait states.
REQ-014 HRESP  out  1  constant 0, OKAY.
REQ-015 x1, y1, x2, y2  out  9 each  active line coordinates to the display generator.

Function
REQ-016 Address phase captured when HSEL && HTRANS[1] && HREADY: register HADDR[4:2] and HWRITE; the data phase is the next cycle.
REQ-017 Register map (word offsets): 0x00 X1, 0x04 Y1, 0x08 X2, 0x0C Y2 (shadow registers), 0x10 CTRL, 0x14 STATUS; 0x18-0x1C unmapped.
REQ-018 Shadow write: HWDATA[8:0] stored, clamped to X_MAX (X1/X2) or Y_MAX (Y1/Y2) when larger; HWDATA[31:9] ignored.
REQ-019 Shadow write takes effect at the clock edge that ends the data phase.
REQ-020 Reads of shadow registers return the zero-extended shadow value; unmapped reads return 0; unmapped and STATUS writes are ignored.
REQ-021 HRDATA is valid during the data phase, driven from registered address-phase information.
REQ-022 CTRL write: bit0 COMMIT, bit1 ABORT; CTRL reads return 0.
REQ-023 VGA_VS passes a 2-flop synchroniser; vs_fall = 1-cycle pulse on a synchronised 1->0 transition.
REQ-024 FSM states: IDLE and PENDING.
REQ-025 IDLE -> PENDING on a CTRL write with COMMIT=1 and ABORT=0.
REQ-026 PENDING -> IDLE on a CTRL write with ABORT=1, leaving the active coordinates unchanged.
REQ-027 PENDING -> IDLE on vs_fall, copying all four shadow registers into x1,y1,x2,y2 on the same edge.
REQ-028 COMMIT while PENDING has no effect; ABORT while IDLE has no effect; when COMMIT and ABORT are both set, ABORT wins.
REQ-029 A COMMIT data phase coincident with vs_fall enters PENDING and waits for the next vs_fall.
REQ-030 A shadow write coincident with the transfer vs_fall latches the old shadow value into the active registers; the new value lands in the shadow only.
REQ-031 frame_cnt, 8-bit, increments on every vs_fall and wraps 255 -> 0.
REQ-032 STATUS read: bit0 = PENDING, bits[15:8] = frame_cnt, other bits 0.
REQ-033 Active outputs change only on vs_fall in PENDING or on reset.

Reset
REQ-034 HRESETn low asynchronously clears: shadow registers, x1/y1/x2/y2, frame_cnt, synchroniser flops, address-phase registers and HRDATA to 0; the FSM to IDLE.
REQ-035 Reset mid-PENDING discards the pending commit; after release, outputs stay 0 until a new COMMIT and vs_fall.

Structure
REQ-036 Package soc_line_pkg holds the register offset constants, the CTRL bit positions, the default X_MAX and Y_MAX values and the FSM state enum.
REQ-037 One sub-module, sync_fall_detect, holds the 2-flop synchroniser and the falling-edge pulse; everything else is flat.

Verification
REQ-038 Write X1=10, Y1=20, X2=300, Y2=200, then COMMIT:
- STATUS reads 0x001 (frame_cnt 0, PENDING set) before the next VS falling edge.
- The outputs become 10/20/300/200 at the first VS falling edge and STATUS bit0 then reads 0.
REQ-039 Write X2=0x1FF and Y2=400, then read back:
- Reads return 319 and 239.
- After a COMMIT and VS falling edge, x2=319 and y2=239.
REQ-040 COMMIT, then ABORT before the VS falling edge:
- The outputs remain at their previous values across 3 frames.
- STATUS bit0 reads 0.
REQ-041 COMMIT data phase in the same cycle as vs_fall:
- The outputs are unchanged at that edge.
- The outputs update at the following vs_fall.
REQ-042 Apply 256 VS pulses: frame_cnt reads 0, then 1 after one more pulse.
REQ-043 Assert HRESETn low while PENDING with the shadow at 50: all outputs read 0, STATUS reads 0, and no update occurs on subsequent VS pulses.
